// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, monitor FSM encoding, window helper
// Shared by the VGA sync driver and the sink-side monitor.
//   VGA_*          : 640x480@60 mode at a 50 MHz clock (clocks per line, lines per frame)
//   ST_*           : monitor FSM state encoding
//   sync_edge_t    : synchronized level plus single-cycle fall/rise pulses
//   in_window()    : half-open range test [lo, lo+len)
package vga_timing_pkg;

  localparam int VGA_H_TOTAL     = 1600;
  localparam int VGA_H_SYNC      = 192;
  localparam int VGA_H_BP        = 96;
  localparam int VGA_H_ACTIVE    = 1280;
  localparam int VGA_V_TOTAL     = 521;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 29;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam logic [1:0] ST_SEEK    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef struct packed {
    logic level;
    logic fall;
    logic rise;
  } sync_edge_t;

  function automatic logic in_window(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// rtl/vga_sync_monitor_if.sv - VGA sync link (HSYNC, VSYNC, RGB) between driver and monitor
// Signals:
//   VGA_HSYNC : horizontal sync, active-low
//   VGA_VSYNC : vertical sync, active-low
//   RGB       : 1-bit pixel data
// Modports: master = driver end, slave = monitor/sink end.
interface vga_sync_monitor_if;
  logic VGA_HSYNC;
  logic VGA_VSYNC;
  logic RGB;

  modport master (output VGA_HSYNC, VGA_VSYNC, RGB);
  modport slave  (input  VGA_HSYNC, VGA_VSYNC, RGB);
endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - 2-flop synchronizer with fall/rise detection on the 2nd/3rd stage
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high; stages reset to 1 (sync idle high)
//   async_i  in  asynchronous active-low sync input
//   edge_o   out synchronized level (3rd stage) and one-cycle fall/rise pulses
module vga_sync_edge
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       async_i,
  output sync_edge_t edge_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign edge_o.level = sync_q[2];
  assign edge_o.fall  = sync_q[2] & ~sync_q[1];
  assign edge_o.rise  = ~sync_q[2] & sync_q[1];

endmodule

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sink-side sync checker: position recovery, timing checks, lock
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   vga          : VGA link (slave end) - VGA_HSYNC, VGA_VSYNC, RGB
//   HCOUNT       : clocks since last HSYNC fall (saturating)
//   VCOUNT       : lines since last VSYNC fall (saturating)
//   LINE_CLKS    : last measured line length, clocks
//   FRAME_LINES  : last measured frame length, lines
//   ACTIVE       : inside the active window while locked
//   PIX_DATA     : synchronized RGB, forced 0 outside ACTIVE
//   LOCKED       : timing locked
//   TIMING_ERR   : sticky fault flag, cleared only by reset
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                     clk,
  input  logic                     reset,
  vga_sync_monitor_if.slave        vga,
  output logic [10:0]              HCOUNT,
  output logic [9:0]               VCOUNT,
  output logic [10:0]              LINE_CLKS,
  output logic [9:0]               FRAME_LINES,
  output logic                     ACTIVE,
  output logic                     PIX_DATA,
  output logic                     LOCKED,
  output logic                     TIMING_ERR
);

  sync_edge_t hs;
  sync_edge_t vs;

  vga_sync_edge u_hsync (.clk(clk), .reset(reset), .async_i(vga.VGA_HSYNC), .edge_o(hs));
  vga_sync_edge u_vsync (.clk(clk), .reset(reset), .async_i(vga.VGA_VSYNC), .edge_o(vs));

  // Only the pulses of HSYNC are needed; its level is not.
  logic unused_hs_level;
  assign unused_hs_level = hs.level;

  logic [10:0] hcount_q, hcount_d, line_clks_q, line_clks_d;
  logic [9:0]  vcount_q, vcount_d, frame_lines_q, frame_lines_d;
  logic [11:0] wd_q, wd_d;       // unsaturated line position for the lost-sync watchdog
  logic [2:0]  vsw_q, vsw_d;     // HSYNC falls seen while VSYNC low
  logic [2:0]  rgb_q, rgb_d;     // same depth as the sync path so pixels line up with HCOUNT
  logic [1:0]  state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        terr_q, terr_d, active_q, active_d, pix_q, pix_d;
  logic [11:0] hcount_inc;
  logic [10:0] vcount_inc;
  logic        line_err, frame_err, any_err;

  assign hcount_inc = {1'b0, hcount_q} + 12'd1;
  assign vcount_inc = {1'b0, vcount_q} + 11'd1;
  assign rgb_d      = {rgb_q[1:0], vga.RGB};

  always_comb begin
    line_err  = (hs.fall && hcount_inc != 12'(H_TOTAL))
             || (hs.rise && hcount_inc != 12'(H_SYNC))
             || (!hs.fall && wd_q == 12'(2 * H_TOTAL - 1));
    frame_err = (vs.fall && vcount_inc != 11'(V_TOTAL))
             || (vs.rise && vsw_q != 3'(V_SYNC));
    any_err   = line_err || frame_err;

    hcount_d      = hcount_q;
    wd_d          = wd_q;
    line_clks_d   = line_clks_q;
    vcount_d      = vcount_q;
    frame_lines_d = frame_lines_q;
    vsw_d         = vsw_q;

    if (hs.fall) begin
      hcount_d    = '0;
      wd_d        = '0;
      line_clks_d = hcount_inc[10:0];
    end else begin
      if (hcount_q != '1) hcount_d = hcount_q + 11'd1;
      if (wd_q != '1)     wd_d     = wd_q + 12'd1;
    end

    // A VSYNC fall always marks a line start, so it counts as the first sync line.
    if (vs.fall) begin
      vcount_d      = '0;
      frame_lines_d = vcount_inc[9:0];
      vsw_d         = 3'd1;
    end else if (hs.fall) begin
      if (vcount_q != '1)              vcount_d = vcount_q + 10'd1;
      if (!vs.level && vsw_q != '1)    vsw_d    = vsw_q + 3'd1;
    end

    active_d = (state_q == ST_LOCKED)
            && in_window(int'(hcount_q), H_SYNC + H_BP, H_ACTIVE)
            && in_window(int'(vcount_q), V_SYNC + V_BP, V_ACTIVE);
    pix_d    = active_d & rgb_q[2];

    state_d = state_q;
    good_d  = good_q;
    terr_d  = terr_q;
    case (state_q)
      ST_SEEK: begin
        // The frame that starts here is only used to find the frame start.
        if (vs.fall) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        if (any_err) begin
          state_d = ST_SEEK;
          terr_d  = 1'b1;
        end else if (vs.fall) begin
          good_d = good_q + 3'd1;
          if (good_q + 3'd1 == 3'(LOCK_FRAMES)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_SEEK;
          terr_d  = 1'b1;
        end
      end
      default: state_d = ST_SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      wd_q          <= '0;
      line_clks_q   <= '0;
      vcount_q      <= '0;
      frame_lines_q <= '0;
      vsw_q         <= '0;
      rgb_q         <= '0;
      state_q       <= ST_SEEK;
      good_q        <= '0;
      terr_q        <= 1'b0;
      active_q      <= 1'b0;
      pix_q         <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      wd_q          <= wd_d;
      line_clks_q   <= line_clks_d;
      vcount_q      <= vcount_d;
      frame_lines_q <= frame_lines_d;
      vsw_q         <= vsw_d;
      rgb_q         <= rgb_d;
      state_q       <= state_d;
      good_q        <= good_d;
      terr_q        <= terr_d;
      active_q      <= active_d;
      pix_q         <= pix_d;
    end
  end

  assign HCOUNT      = hcount_q;
  assign VCOUNT      = vcount_q;
  assign LINE_CLKS   = line_clks_q;
  assign FRAME_LINES = frame_lines_q;
  assign ACTIVE      = active_q;
  assign PIX_DATA    = pix_q;
  assign LOCKED      = (state_q == ST_LOCKED);
  assign TIMING_ERR  = terr_q;

endmodule
